// File: rtl/week_5_pla_pkg.sv
// Shared types and constants for the programmable PLA: controller states,
// AND-row literal layout and the program-port width helper.
package week_5_pla_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Within an AND row, variable i owns bits 2i (true) and 2i+1 (complement).
    localparam int LIT_TRUE_OFS = 0;
    localparam int LIT_COMP_OFS = 1;

    function automatic int prog_dw(input int n_in, input int n_out);
        return (2 * n_in > n_out) ? 2 * n_in : n_out;
    endfunction

endpackage

// File: rtl/week_5_pla_term.sv
// One product-term evaluator: AND of the literals selected by the row.
// An empty row, or a row asking for both polarities of a variable, yields 0.
module week_5_pla_term
    import week_5_pla_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [2*N_IN-1:0] i_and_row,
    input  logic [N_IN-1:0]   i_data,
    output logic              o_term
);

    logic [N_IN-1:0] w_lit_ok;

    always_comb begin
        w_lit_ok = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_lit_ok[i] = (!i_and_row[2*i+LIT_TRUE_OFS] ||  i_data[i]) &&
                          (!i_and_row[2*i+LIT_COMP_OFS] || !i_data[i]);
        end
    end

    assign o_term = (|i_and_row) && (&w_lit_ok);

endmodule

// File: rtl/week_5_pla_programmable.sv
// Run-time programmable PLA with a two-stage pipeline (terms, then OR plane).
// state    | meaning
// ST_RUN   | accept plane writes or input vectors
// ST_CLEAR | zero one AND/OR row pair per cycle, rows 0..N_TERMS-1
module week_5_pla_programmable
    import week_5_pla_pkg::*;
#(
    parameter  int N_IN    = 4,
    parameter  int N_TERMS = 8,
    parameter  int N_OUT   = 2,
    localparam int AW      = $clog2(N_TERMS),
    localparam int DW      = prog_dw(N_IN, N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_prog_en,
    input  logic             i_prog_sel,
    input  logic [AW-1:0]    i_prog_addr,
    input  logic [DW-1:0]    i_prog_data,
    input  logic             i_prog_clr,
    output logic             o_prog_ready,
    input  logic             i_in_valid,
    input  logic [N_IN-1:0]  i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [N_OUT-1:0] o_out_data
);

    state_e                           r_state;
    state_e                           w_state_nxt;
    logic [AW-1:0]                    r_clr_cnt;
    logic [N_TERMS-1:0][2*N_IN-1:0]   r_and_plane;
    logic [N_TERMS-1:0][N_OUT-1:0]    r_or_plane;
    logic                             r_s1_valid;
    logic [N_TERMS-1:0]               r_s1_terms;
    logic                             r_out_valid;
    logic [N_OUT-1:0]                 r_out_data;
    logic [N_TERMS-1:0]               w_terms;
    logic [N_OUT-1:0]                 w_or_out;
    logic                             w_clr_start;
    logic                             w_clr_last;
    logic                             w_addr_ok;
    logic                             w_write;
    logic                             w_accept;

    assign w_addr_ok   = ({1'b0, i_prog_addr} < (AW+1)'(N_TERMS));
    assign w_clr_last  = (r_clr_cnt == AW'(N_TERMS - 1));
    assign w_clr_start = i_prog_clr && o_prog_ready;
    // Clear wins over a simultaneous write; out-of-range writes are swallowed.
    assign w_write     = i_prog_en && o_prog_ready && !i_prog_clr && w_addr_ok;
    assign w_accept    = i_in_valid && o_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_clr_start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_clr_last)  w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Holding prog_ready low while stage 1 is busy keeps in-flight vectors on one plane.
    always_comb begin
        o_prog_ready = 1'b0;
        o_in_ready   = 1'b0;
        if (r_state == ST_RUN) begin
            o_prog_ready = !r_s1_valid;
            o_in_ready   = !i_prog_en && !i_prog_clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt   <= '0;
            r_and_plane <= '0;
            r_or_plane  <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_and_plane[r_clr_cnt] <= '0;
            r_or_plane[r_clr_cnt]  <= '0;
            r_clr_cnt              <= r_clr_cnt + 1'b1;
        end else begin
            r_clr_cnt <= '0;
            if (w_write) begin
                if (i_prog_sel) r_or_plane[i_prog_addr]  <= i_prog_data[N_OUT-1:0];
                else            r_and_plane[i_prog_addr] <= i_prog_data[2*N_IN-1:0];
            end
        end
    end

    for (genvar j = 0; j < N_TERMS; j++) begin : g_term
        week_5_pla_term #(.N_IN(N_IN)) u_term (
            .i_and_row (r_and_plane[j]),
            .i_data    (i_in_data),
            .o_term    (w_terms[j])
        );
    end

    always_comb begin
        w_or_out = '0;
        for (int k = 0; k < N_OUT; k++) begin
            for (int j = 0; j < N_TERMS; j++) begin
                if (r_s1_terms[j] && r_or_plane[j][k]) w_or_out[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_terms  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_s1_valid  <= w_accept;
            if (w_accept) r_s1_terms <= w_terms;
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) r_out_data <= w_or_out;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_week_5_pla_programmable.sv
// Self-checking bench for week_5_pla_programmable: directed program/clear/collision
// steps followed by random traffic, all checked against a plane-level reference.
module tb_week_5_pla_programmable;

    localparam int N_IN    = 4;
    localparam int N_TERMS = 8;
    localparam int N_OUT   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       prog_en = 1'b0, prog_sel = 1'b0, prog_clr = 1'b0;
    logic [2:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       prog_ready, in_ready, out_valid;
    logic [1:0] out_data;

    week_5_pla_programmable #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_prog_en    (prog_en),
        .i_prog_sel   (prog_sel),
        .i_prog_addr  (prog_addr),
        .i_prog_data  (prog_data),
        .i_prog_clr   (prog_clr),
        .o_prog_ready (prog_ready),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [1:0] val;
    } exp_t;

    logic [7:0] m_and [N_TERMS];
    logic [1:0] m_or  [N_TERMS];
    int         m_clear_left;
    bit         m_inflight;
    logic [1:0] m_last_out;
    exp_t       q[$];
    int         cyc;
    int         checks;
    int         errors;

    // A term fires when its row is non-empty and every requested literal is true.
    function automatic logic [1:0] ref_eval(input logic [3:0] d);
        logic [7:0] lits;
        logic [1:0] y;
        y = '0;
        for (int i = 0; i < N_IN; i++) begin
            lits[2*i]   = d[i];
            lits[2*i+1] = ~d[i];
        end
        for (int j = 0; j < N_TERMS; j++) begin
            if (m_and[j] != 8'h00 && (m_and[j] & lits) == m_and[j]) y = y | m_or[j];
        end
        return y;
    endfunction

    function automatic logic [7:0] rnd_and();
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < N_IN; i++) begin
            case ($urandom_range(0, 5))
                1, 2:    r[2*i]   = 1'b1;
                3, 4:    r[2*i+1] = 1'b1;
                5:       begin r[2*i] = 1'b1; r[2*i+1] = 1'b1; end
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        foreach (m_and[j]) m_and[j] = '0;
        foreach (m_or[j])  m_or[j]  = '0;
        m_clear_left = 0;
        m_inflight   = 1'b0;
        m_last_out   = '0;
        q.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input bit en, input bit sel, input logic [2:0] addr,
                        input logic [7:0] data, input bit clr, input bit vld,
                        input logic [3:0] din);
        bit exp_pr, exp_ir, acc, exp_v;
        prog_en = en; prog_sel = sel; prog_addr = addr; prog_data = data;
        prog_clr = clr; in_valid = vld; in_data = din;
        #1;
        exp_pr = (m_clear_left == 0) && !m_inflight;
        exp_ir = (m_clear_left == 0) && !en && !clr;
        chk("prog_ready", {31'b0, prog_ready}, {31'b0, exp_pr});
        chk("in_ready",   {31'b0, in_ready},   {31'b0, exp_ir});
        acc = vld && exp_ir;
        if (acc) q.push_back('{due: cyc + 2, val: ref_eval(din)});
        if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (clr && exp_pr) begin
            m_clear_left = N_TERMS;
            foreach (m_and[j]) m_and[j] = '0;
            foreach (m_or[j])  m_or[j]  = '0;
        end else if (en && exp_pr && int'(addr) < N_TERMS) begin
            if (sel) m_or[addr]  = data[1:0];
            else     m_and[addr] = data;
        end
        m_inflight = acc;
        @(posedge clk); #1;
        cyc++;
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        if (exp_v) begin
            m_last_out = q[0].val;
            void'(q.pop_front());
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        chk("out_data",  {30'b0, out_data},  {30'b0, m_last_out});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 8'h00, 0, 0, 4'h0);
    endtask

    task automatic load(input bit sel, input logic [2:0] addr, input logic [7:0] data);
        step(1, sel, addr, data, 0, 0, 4'h0);
    endtask

    task automatic vec(input logic [3:0] din);
        step(0, 0, 3'd0, 8'h00, 0, 1, din);
    endtask

    task automatic do_reset();
        prog_en = 0; prog_sel = 0; prog_clr = 0; in_valid = 0;
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  {30'b0, out_data},  32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_out_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic load_drawing02();
        load(0, 3'd0, 8'h55); load(0, 3'd1, 8'h65); load(0, 3'd2, 8'hAA);
        load(0, 3'd3, 8'h56); load(0, 3'd4, 8'h99);
        load(1, 3'd0, 8'h02); load(1, 3'd1, 8'h02); load(1, 3'd2, 8'h02);
        load(1, 3'd3, 8'h01); load(1, 3'd4, 8'h01);
    endtask

    logic [3:0] vecs [6];

    initial begin
        checks = 0; errors = 0; cyc = 0;
        model_reset();
        vecs[0] = 4'b1111; vecs[1] = 4'b1110; vecs[2] = 4'b1011;
        vecs[3] = 4'b0101; vecs[4] = 4'b0000; vecs[5] = 4'b0011;

        do_reset();
        vec(4'b1111); idle(2);

        load_drawing02();
        for (int i = 0; i < 6; i++) begin
            vec(vecs[i]); idle(2);
        end
        // Fixed Drawing 02 answers, independent of the reference model.
        vec(4'b1110); idle(1);
        chk("d02_1110", {30'b0, out_data}, 32'd1);
        vec(4'b0000); idle(1);
        chk("d02_0000", {30'b0, out_data}, 32'd2);

        for (int i = 0; i < 6; i++) vec(vecs[i]);
        idle(3);

        step(0, 0, 3'd0, 8'h00, 1, 0, 4'h0);
        idle(9);
        vec(4'b1111); idle(2);
        chk("after_clear_1111", {30'b0, out_data}, 32'd0);

        load_drawing02();
        step(1, 0, 3'd5, 8'h00, 0, 1, 4'b1111);
        step(1, 1, 3'd5, 8'h03, 0, 1, 4'b1111);
        idle(1);
        vec(4'b1111);
        step(1, 0, 3'd0, 8'h00, 0, 0, 4'h0);
        step(1, 0, 3'd0, 8'h00, 0, 0, 4'h0);
        idle(1);
        vec(4'b1111); idle(2);

        load_drawing02();
        step(0, 0, 3'd0, 8'h00, 1, 0, 4'h0);
        idle(2);
        do_reset();
        vec(4'b1110); vec(4'b1111); idle(3);

        load_drawing02();
        for (int i = 0; i < 300; i++) begin
            bit         en, sel, clr, vld;
            logic [7:0] d;
            en  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 1);
            clr = ($urandom_range(0, 39) == 0);
            vld = $urandom_range(0, 1);
            d   = sel ? 8'($urandom) : rnd_and();
            step(en, sel, 3'($urandom_range(0, 7)), d, clr, vld, 4'($urandom));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/week_5_pla_programmable.md
# week_5_pla_programmable

Parametrised, run-time programmable PLA with a two-stage registered evaluation pipeline. It generalises the fixed 4-input/2-output Drawing 02 PLA to N_IN inputs, N_TERMS product terms and N_OUT outputs. AND and OR planes are loaded through a write port and can be bulk-cleared by a sequenced clear. It sits behind input-vector sources in the lab designs and replaces hard-wired sum-of-products blocks.

## Interface
- N_IN, 4, number of input variables
- N_TERMS, 8, number of product terms (rows)
- N_OUT, 2, number of OR-plane outputs
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- prog_en  in  1  plane write strobe
- prog_sel  in  1  0 = AND row, 1 = OR row
- prog_addr  in  $clog2(N_TERMS)  term index
- prog_data  in  max(2*N_IN, N_OUT)  row contents; OR write uses bits [N_OUT-1:0]
- prog_clr  in  1  start full-plane clear
- prog_ready  out  1  write/clear accepted when high
- in_valid  in  1  input vector present
- in_data  in  N_IN  input vector; bit N_IN-1 = A (MSB) … bit 0 = last variable
- in_ready  out  1  vector accepted when in_valid && in_ready
- out_valid  out  1  one-cycle pulse per evaluated vector
- out_data  out  N_OUT  result; bit N_OUT-1 = first output (Y)

## Operation
- AND row j, 2*N_IN bits: bit 2i selects true literal in_data[i], bit 2i+1 selects complement. The term is the AND of the selected literals. An all-zero row makes the term 0, never 1. Selecting both polarities of one variable also makes the term 0.
- OR row j, N_OUT bits: bit k set means term j feeds output k. An output with no feeding terms is 0.
- States: RUN, CLEAR.
- RUN:
  - prog_ready = !s1_valid.
  - in_ready = !prog_en && !prog_clr.
  - Writes and vector acceptance are therefore never in the same cycle.
- prog_clr && prog_ready moves the block to CLEAR. prog_clr has priority over prog_en in the same cycle; the write is dropped.
- CLEAR:
  - A counter walks j = 0 … N_TERMS-1, zeroing AND row j and OR row j, one row per cycle.
  - After row N_TERMS-1 is cleared, the block returns to RUN. CLEAR lasts exactly N_TERMS cycles.
  - prog_ready = 0 and in_ready = 0 throughout.
- A write with prog_addr ≥ N_TERMS is accepted and ignored.
- Reset:
  - State = RUN, both planes all-zero, pipeline valid flags cleared.
  - out_valid = 0 and out_data = 0.
  - After reset, prog_ready = 1 and in_ready = 1 (with strobes low).
- Reset mid-CLEAR or mid-pipeline aborts the clear or evaluation immediately; no partial output is produced.

## Timing
- Stage 1: at the accepting edge, product terms are computed from in_data and the current AND plane and registered, with s1_valid.
- Stage 2: at the next edge, the OR plane is applied and the result registered into out_data/out_valid.
- Latency: a vector presented in cycle n appears on out_data with out_valid = 1 in cycle n+2. Throughput is one vector per cycle.
- out_data holds its last value while out_valid = 0.
- A plane write at edge E affects only vectors accepted after E. Because prog_ready is low while s1_valid is set, an in-flight vector never sees a mixed plane.
- Write handshake: prog_en sampled when prog_ready = 1. When prog_ready = 0 the source holds prog_en and data until accepted.

## Structure
- Shared package week_5_pla_pkg: state enum (RUN, CLEAR), the literal-encoding constants (true = even bit, complement = odd bit), and a helper function for the prog_data width.
- One sub-module, week_5_pla_term: a single product-term evaluator (AND row plus in_data gives the term bit), instantiated N_TERMS times by generate.
- Planes, clear counter, FSM and pipeline registers live in the top module.

## Test plan
- Reset: hold rst_n = 0 with strobes idle, then release.
  - During reset: out_valid = 0, out_data = 00.
  - After release: prog_ready = 1, in_ready = 1.
  - Vector 1111 then gives out_data = 00 two cycles later.
- Load the Drawing 02 program.
  - AND rows 0–4: 0x55, 0x65, 0xAA, 0x56, 0x99.
  - OR rows 0–2: 2'b10; OR rows 3–4: 2'b01.
  - Apply vectors: 1111 → 10, 1110 → 01, 1011 → 10, 0101 → 01, 0000 → 10, 0011 → 00.
- Streaming: present the six vectors above back-to-back.
  - out_valid stays high for 6 consecutive cycles starting 2 cycles after the first vector.
  - Results appear in input order.
- Clear: pulse prog_clr after the program is loaded.
  - prog_ready and in_ready stay low for exactly 8 cycles.
  - Afterwards, vector 1111 gives 00.
- Collisions:
  - prog_en and in_valid in the same cycle: in_ready = 0 and the write lands.
  - prog_en one cycle after an accepted vector: prog_ready = 0, the write lands one cycle later, and that vector's result uses the old plane.
- Reset mid-CLEAR: assert rst_n = 0 at clear cycle 3.
  - The block returns to RUN with all planes zero.
  - No out_valid pulse occurs.
